// File: rtl/comp_conv_sched_pkg.sv
// Shared definitions for the round-robin sign-magnitude converter slice.
// Conversion modes and output-slot state encodings.
package comp_conv_sched_pkg;

    localparam logic MODE_ONES = 1'b0;
    localparam logic MODE_TWOS = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/comp_conv_sched_sm2comp.sv
// Combinational sign-magnitude to ones'/two's complement converter.
// Positive words pass through; the magnitude carry-out is dropped.
module sm2comp
    import comp_conv_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic             twos,
    output logic [WIDTH-1:0] y
);

    localparam logic [WIDTH-2:0] MAG_ONE = {{(WIDTH-2){1'b0}}, 1'b1};

    logic [WIDTH-2:0] inv;
    logic [WIDTH-2:0] neg;

    assign inv = ~x[WIDTH-2:0];
    assign neg = inv + MAG_ONE;

    always_comb begin
        y = x;
        if (x[WIDTH-1]) begin
            y = {1'b1, (twos == MODE_TWOS) ? neg : inv};
        end
    end

endmodule

// File: rtl/comp_conv_sched.sv
// Round-robin scheduler sharing one complement converter among NREQ
// requesters, with a one-entry registered valid/ready output slot.
module comp_conv_sched
    import comp_conv_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  cfg_twos,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_id,
    input  logic                  out_ready,
    output logic [CNTW-1:0]       conv_cnt
);

    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
    localparam logic [IDW-1:0] ID_ONE  = IDW'(1);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    state_t           state;
    state_t           state_nx;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   grant;
    logic [IDW:0]     idx;
    logic             found;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] words [NREQ];
    logic [WIDTH-1:0] conv_y;

    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign words[i] = req_data[i*WIDTH +: WIDTH];
    end

    assign out_valid = (state == ST_FULL);
    assign slot_free = ~out_valid | out_ready;

    // Ascending search from ptr with wrap-around
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                grant = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found && slot_free && !rst) req_ready[grant] = 1'b1;
    end

    assign accept = |req_ready;

    sm2comp #(.WIDTH(WIDTH)) u_conv (
        .x    (words[grant]),
        .twos (cfg_twos),
        .y    (conv_y)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_EMPTY: if (accept) state_nx = ST_FULL;
            ST_FULL: begin
                if (accept)         state_nx = ST_FULL;
                else if (out_ready) state_nx = ST_EMPTY;
            end
            default: state_nx = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_id   <= '0;
            ptr      <= '0;
            conv_cnt <= '0;
        end else begin
            if (accept) begin
                out_data <= conv_y;
                out_id   <= grant;
                ptr      <= (grant == LAST_ID) ? '0 : grant + ID_ONE;
            end
            if (out_valid && out_ready && !(&conv_cnt)) begin
                conv_cnt <= conv_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_comp_conv_sched.sv
// Bench for comp_conv_sched: directed vector table, random traffic
// against a behavioural model, and a counter saturation run.
module tb_comp_conv_sched;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int CNTW  = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  cfg_twos;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic                  out_ready;
    logic [CNTW-1:0]       conv_cnt;

    comp_conv_sched #(
        .WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cfg_twos  (cfg_twos),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .conv_cnt  (conv_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        twos;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_v;
        logic [7:0]  e_d;
        logic [1:0]  e_id;
        logic [15:0] e_cnt;
    } vec_t;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit       m_valid;
    bit [7:0] m_data;
    int       m_id;
    int       m_cnt;
    int       m_ptr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit [7:0] conv_ref(input bit [7:0] x, input bit t);
        int mag;
        int r;
        if (x < 8'h80) return x;
        mag = int'(x) - 128;
        if (!t) r = 127 - mag;
        else    r = (128 - mag) % 128;
        return 8'(128 + r);
    endfunction

    task automatic model_step(input bit r, input bit [3:0] rv,
                              input bit [31:0] rd, input bit t,
                              input bit o, output vec_t v);
        int g;
        int i;
        g = -1;
        if (!r && (!m_valid || o)) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (g < 0 && ((rv >> i) & 4'd1) != 4'd0) g = i;
            end
        end
        v.rst = r; v.rv = rv; v.rd = rd; v.twos = t; v.ordy = o;
        v.e_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
        if (r) begin
            m_valid = 0; m_data = 0; m_id = 0; m_cnt = 0; m_ptr = 0;
        end else begin
            if (m_valid && o && m_cnt != 65535) m_cnt++;
            if (g >= 0) begin
                m_valid = 1;
                m_data  = conv_ref(8'(rd >> (g * 8)), t);
                m_id    = g;
                m_ptr   = (g + 1) % NREQ;
            end else if (m_valid && o) begin
                m_valid = 0;
            end
        end
        v.e_v = m_valid; v.e_d = m_data;
        v.e_id = 2'(m_id); v.e_cnt = 16'(m_cnt);
    endtask

    // Drive at posedge+1, check req_ready mid-cycle, outputs after edge
    task automatic cycle(input vec_t v);
        rst = v.rst; req_valid = v.rv; req_data = v.rd;
        cfg_twos = v.twos; out_ready = v.ordy;
        #2;
        chk("req_ready", 32'(req_ready), 32'(v.e_rdy));
        @(posedge clk);
        #1;
        n_vec++;
        chk("out_valid", 32'(out_valid), 32'(v.e_v));
        chk("out_data", 32'(out_data), 32'(v.e_d));
        chk("out_id", 32'(out_id), 32'(v.e_id));
        chk("conv_cnt", 32'(conv_cnt), 32'(v.e_cnt));
    endtask

    localparam logic [31:0] RR = 32'h8403_8201;

    vec_t tbl[22];
    vec_t v;
    bit [3:0]  rv;
    bit [31:0] rd;

    initial begin
        //        rst  rv      rd            tw ordy rdy     v  data  id cnt
        tbl[0]  = '{1, 4'h0, 32'h0,          1, 1, 4'b0000, 0, 8'h00, 0, 0};
        tbl[1]  = '{0, 4'h1, 32'h0000_0025,  1, 1, 4'b0001, 1, 8'h25, 0, 0};
        tbl[2]  = '{0, 4'h0, 32'h0,          1, 1, 4'b0000, 0, 8'h25, 0, 1};
        tbl[3]  = '{0, 4'h4, 32'h0085_0000,  0, 1, 4'b0100, 1, 8'hFA, 2, 1};
        tbl[4]  = '{0, 4'h4, 32'h0085_0000,  1, 1, 4'b0100, 1, 8'hFB, 2, 2};
        tbl[5]  = '{0, 4'h1, 32'h0000_0080,  0, 1, 4'b0001, 1, 8'hFF, 0, 3};
        tbl[6]  = '{0, 4'h1, 32'h0000_0080,  1, 1, 4'b0001, 1, 8'h80, 0, 4};
        tbl[7]  = '{0, 4'h0, 32'h0,          1, 1, 4'b0000, 0, 8'h80, 0, 5};
        tbl[8]  = '{1, 4'h0, 32'h0,          1, 1, 4'b0000, 0, 8'h00, 0, 0};
        tbl[9]  = '{0, 4'hF, RR,             1, 1, 4'b0001, 1, 8'h01, 0, 0};
        tbl[10] = '{0, 4'hF, RR,             1, 1, 4'b0010, 1, 8'hFE, 1, 1};
        tbl[11] = '{0, 4'hF, RR,             1, 1, 4'b0100, 1, 8'h03, 2, 2};
        tbl[12] = '{0, 4'hF, RR,             1, 1, 4'b1000, 1, 8'hFC, 3, 3};
        tbl[13] = '{0, 4'hF, RR,             1, 1, 4'b0001, 1, 8'h01, 0, 4};
        tbl[14] = '{0, 4'hF, RR,             0, 0, 4'b0000, 1, 8'h01, 0, 4};
        tbl[15] = '{0, 4'hF, RR,             0, 0, 4'b0000, 1, 8'h01, 0, 4};
        tbl[16] = '{0, 4'hF, RR,             0, 0, 4'b0000, 1, 8'h01, 0, 4};
        tbl[17] = '{0, 4'h2, RR,             0, 1, 4'b0010, 1, 8'hFD, 1, 5};
        tbl[18] = '{0, 4'h0, RR,             0, 1, 4'b0000, 0, 8'hFD, 1, 6};
        tbl[19] = '{0, 4'h2, RR,             1, 1, 4'b0010, 1, 8'hFE, 1, 6};
        tbl[20] = '{1, 4'hF, RR,             1, 0, 4'b0000, 0, 8'h00, 0, 0};
        tbl[21] = '{0, 4'hF, RR,             1, 1, 4'b0001, 1, 8'h01, 0, 0};

        rst = 1'b1; req_valid = '0; req_data = '0;
        cfg_twos = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 22; n++) cycle(tbl[n]);

        // Random traffic; requesters hold valid and data until accepted
        rv = '0;
        rd = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (((rv >> i) & 4'd1) == 4'd0) begin
                    if ($urandom_range(1) == 1) rv = rv | 4'(1 << i);
                    rd = (rd & ~(32'hFF << (i * 8))) |
                         (32'($urandom_range(255)) << (i * 8));
                end
            end
            model_step(n == 0 || $urandom_range(99) == 0, rv, rd,
                       1'($urandom_range(1)), $urandom_range(9) < 7, v);
            cycle(v);
            rv = rv & ~v.e_rdy;
        end

        // Counter saturation under continuous traffic
        model_step(1, 4'h1, 32'h0000_0085, 1, 1, v);
        cycle(v);
        for (int n = 0; n < 65540; n++) begin
            model_step(0, 4'h1, 32'h0000_0085, 1, 1, v);
            cycle(v);
        end
        chk("conv_cnt_sat", 32'(conv_cnt), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
